snn_rate_encoder: RTL and testbench

Upstream stage of the SNN compute core: holds one input image (8-bit pixels written by the host) and converts it into Bernoulli rate-coded spike trains, one spike frame per time step. Each pixel spikes with probability pixel/256 per step, using a 16-bit LFSR. Spikes leave as SPIKE_WORD-bit words over a valid/ready stream that the compute core consumes.

---
 rtl/snn_enc_pkg.sv | 20 ++
 rtl/snn_lfsr16.sv | 30 +++
 rtl/snn_rate_encoder.sv | 177 +++++++++++++++++
 tb/tb_snn_rate_encoder.sv | 467 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_enc_pkg.sv
// Shared types and constants for the SNN rate encoder.
// Holds the FSM encoding and the 16-bit Galois LFSR step.
package snn_enc_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_OUT,
    S_DONE
  } enc_state_t;

  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;

  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/snn_lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load.
// Advances one step per asserted i_advance.
module snn_lfsr16
  import snn_enc_pkg::*;
#(
  parameter logic [15:0] RESET_VAL = LFSR_SEED_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_advance,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RESET_VAL;
    end else if (i_load) begin
      r_state <= i_seed;
    end else if (i_advance) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/snn_rate_encoder.sv
// Bernoulli rate encoder: pixel RAM plus LFSR compare,
// streaming one SPIKE_WORD-bit spike word per handshake.
module snn_rate_encoder
  import snn_enc_pkg::*;
#(
  parameter int          NUM_PIXELS = 3072,
  parameter int          TIME_STEPS = 100,
  parameter int          SPIKE_WORD = 32,
  parameter logic [15:0] LFSR_SEED  = LFSR_SEED_DEF,
  localparam int NUM_WORDS = NUM_PIXELS / SPIKE_WORD,
  localparam int AW        = $clog2(NUM_PIXELS),
  localparam int WW        = $clog2(NUM_WORDS),
  localparam int TW        = $clog2(TIME_STEPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_pix_wr_en,
  input  logic [AW-1:0]         i_pix_wr_addr,
  input  logic [7:0]            i_pix_wr_data,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_spk_valid,
  input  logic                  i_spk_ready,
  output logic [SPIKE_WORD-1:0] o_spk_data,
  output logic [WW-1:0]         o_spk_word_idx,
  output logic [TW-1:0]         o_spk_step,
  output logic                  o_spk_last
);

  localparam int CW = $clog2(SPIKE_WORD + 1);
  localparam int OW = $clog2(SPIKE_WORD);

  enc_state_t r_state;
  enc_state_t w_next;

  logic [CW-1:0]         r_cnt;
  logic [OW-1:0]         r_off;
  logic                  r_rd_vld;
  logic [7:0]            r_mem [NUM_PIXELS];
  logic [7:0]            r_rd_data;
  logic [SPIKE_WORD-1:0] r_asm;
  logic [WW-1:0]         r_word;
  logic [TW-1:0]         r_step;

  logic          w_init;
  logic          w_rd_en;
  logic          w_hs;
  logic          w_cmp;
  logic          w_spike;
  logic          w_word_end;
  logic          w_last_pos;
  logic          w_unused_lfsr;
  logic [AW-1:0] w_rd_addr;
  logic [15:0]   w_lfsr;

  snn_lfsr16 #(
    .RESET_VAL(LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_init),
    .i_seed   (LFSR_SEED),
    .i_advance(w_cmp),
    .o_state  (w_lfsr)
  );

  assign w_word_end = (r_word == WW'(NUM_WORDS - 1));
  assign w_last_pos = w_word_end
                    && (r_step == TW'(TIME_STEPS - 1));
  assign w_rd_addr  = AW'(32'(r_word) * SPIKE_WORD
                    + 32'(r_cnt));
  assign w_cmp      = r_rd_vld && !i_abort;
  assign w_spike    = r_rd_data > w_lfsr[7:0];
  assign w_unused_lfsr = ^w_lfsr[15:8];

  always_comb begin
    w_next  = r_state;
    w_init  = 1'b0;
    w_rd_en = 1'b0;
    w_hs    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_FILL;
          w_init = 1'b1;
        end
      end
      S_FILL: begin
        w_rd_en = (r_cnt < CW'(SPIKE_WORD));
        if (r_rd_vld && r_off == OW'(SPIKE_WORD - 1)) begin
          w_next = S_OUT;
        end
      end
      S_OUT: begin
        if (i_spk_ready) begin
          w_hs   = 1'b1;
          w_next = w_last_pos ? S_DONE : S_FILL;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
        if (i_start) begin
          w_next = S_FILL;
          w_init = 1'b1;
        end
      end
    endcase
    // abort outranks start and the output handshake
    if (i_abort) begin
      w_next  = S_IDLE;
      w_init  = 1'b0;
      w_rd_en = 1'b0;
      w_hs    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_off    <= '0;
      r_rd_vld <= 1'b0;
      r_asm    <= '0;
      r_word   <= '0;
      r_step   <= '0;
    end else begin
      r_rd_vld <= w_rd_en;
      r_off    <= r_cnt[OW-1:0];
      if (w_cmp) begin
        r_asm[r_off] <= w_spike;
      end
      if (w_init) begin
        r_cnt  <= '0;
        r_word <= '0;
        r_step <= '0;
      end else if (w_hs && !w_last_pos) begin
        r_cnt <= '0;
        if (w_word_end) begin
          r_word <= '0;
          r_step <= r_step + TW'(1);
        end else begin
          r_word <= r_word + WW'(1);
        end
      end else if (w_rd_en) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // image storage is not reset; host rewrites it per image
  always_ff @(posedge clk) begin
    if (i_pix_wr_en && !o_busy
        && 32'(i_pix_wr_addr) < NUM_PIXELS) begin
      r_mem[i_pix_wr_addr] <= i_pix_wr_data;
    end
    r_rd_data <= r_mem[w_rd_addr];
  end

  assign o_busy         = (r_state == S_FILL)
                        || (r_state == S_OUT);
  assign o_done         = (r_state == S_DONE);
  assign o_spk_valid    = (r_state == S_OUT);
  assign o_spk_data     = r_asm;
  assign o_spk_word_idx = r_word;
  assign o_spk_step     = r_step;
  assign o_spk_last     = o_spk_valid && w_last_pos;

endmodule

// File: tb/tb_snn_rate_encoder.sv
// Randomized bench for snn_rate_encoder (reduced image size)
// against a plain-arithmetic Bernoulli/LFSR reference.
module tb_snn_rate_encoder;

  localparam int NP  = 128;
  localparam int TS  = 8;
  localparam int SW  = 32;
  localparam int NW  = NP / SW;
  localparam int AW  = $clog2(NP);
  localparam int WIW = $clog2(NW);
  localparam int STW = $clog2(TS);
  localparam logic [15:0] SEED = 16'hACE1;

  logic           clk;
  logic           rst_n;
  logic           i_pix_wr_en;
  logic [AW-1:0]  i_pix_wr_addr;
  logic [7:0]     i_pix_wr_data;
  logic           i_start;
  logic           i_abort;
  logic           o_busy;
  logic           o_done;
  logic           o_spk_valid;
  logic           i_spk_ready;
  logic [SW-1:0]  o_spk_data;
  logic [WIW-1:0] o_spk_word_idx;
  logic [STW-1:0] o_spk_step;
  logic           o_spk_last;

  snn_rate_encoder #(
    .NUM_PIXELS(NP),
    .TIME_STEPS(TS),
    .SPIKE_WORD(SW),
    .LFSR_SEED (SEED)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pix_wr_en   (i_pix_wr_en),
    .i_pix_wr_addr (i_pix_wr_addr),
    .i_pix_wr_data (i_pix_wr_data),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_spk_valid   (o_spk_valid),
    .i_spk_ready   (i_spk_ready),
    .o_spk_data    (o_spk_data),
    .o_spk_word_idx(o_spk_word_idx),
    .o_spk_step    (o_spk_step),
    .o_spk_last    (o_spk_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]    img [NP];
  logic [SW-1:0] exp_q [$];
  logic [SW-1:0] got_d [$];
  int            got_w [$];
  int            got_s [$];
  bit            got_l [$];
  int            n_done;
  int            stab_err;
  int            pass_cnt = 0;
  int            tot_cnt  = 0;

  // Reference: each pixel spikes when it exceeds the LFSR low
  // byte, LFSR stepping once per pixel in stream order.
  task automatic build_model();
    logic [15:0]   l;
    logic [SW-1:0] w;
    exp_q.delete();
    l = SEED;
    for (int s = 0; s < TS; s++) begin
      for (int k = 0; k < NW; k++) begin
        w = '0;
        for (int b = 0; b < SW; b++) begin
          w[b] = (img[k*SW+b] > l[7:0]);
          l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        end
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic load_image();
    for (int p = 0; p < NP; p++) begin
      i_pix_wr_en   = 1'b1;
      i_pix_wr_addr = AW'(p);
      i_pix_wr_data = img[p];
      @(negedge clk);
    end
    i_pix_wr_en = 1'b0;
  endtask

  task automatic do_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // rmode 0: ready=1, 1: random, 2: stall word 1 of step 0
  task automatic collect(input int rmode, input int stall_cyc,
                         input int stop_beats);
    int            cyc;
    int            stalled;
    bit            pst;
    logic [SW-1:0] pd;
    int            pw;
    int            ps;
    bit            pl;
    cyc = 0; stalled = 0; pst = 0;
    pd = '0; pw = 0; ps = 0; pl = 0;
    got_d.delete(); got_w.delete();
    got_s.delete(); got_l.delete();
    n_done = 0;
    forever begin
      if (pst && (!o_spk_valid || o_spk_data !== pd
          || int'(o_spk_word_idx) != pw
          || int'(o_spk_step) != ps || o_spk_last !== pl))
        stab_err++;
      if (o_done) begin
        n_done++;
        break;
      end
      case (rmode)
        0: i_spk_ready = 1'b1;
        1: i_spk_ready = 1'($urandom_range(0, 1));
        default: i_spk_ready = !(o_spk_valid
                 && o_spk_word_idx == 1 && o_spk_step == 0
                 && stalled < stall_cyc);
      endcase
      if (rmode == 2 && !i_spk_ready) stalled++;
      if (o_spk_valid && i_spk_ready) begin
        got_d.push_back(o_spk_data);
        got_w.push_back(int'(o_spk_word_idx));
        got_s.push_back(int'(o_spk_step));
        got_l.push_back(o_spk_last);
        if (got_d.size() == stop_beats) break;
      end
      pst = o_spk_valid && !i_spk_ready;
      pd = o_spk_data; pw = int'(o_spk_word_idx);
      ps = int'(o_spk_step); pl = o_spk_last;
      cyc++;
      if (cyc > 20000) begin
        tot_cnt++;
        $display("FAIL collect_timeout got %0d beats, need done",
                 got_d.size());
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_pix_wr_en = 0; i_pix_wr_addr = '0; i_pix_wr_data = '0;
    i_start = 0; i_abort = 0; i_spk_ready = 0;
    repeat (3) @(negedge clk);
    tot_cnt++;
    if ({o_busy, o_done, o_spk_valid, o_spk_last} !== 4'b0000)
      $display("FAIL reset_flags got %b need 0000",
               {o_busy, o_done, o_spk_valid, o_spk_last});
    else pass_cnt++;
    tot_cnt++;
    if (o_spk_data !== '0 || o_spk_word_idx !== '0
        || o_spk_step !== '0)
      $display("FAIL reset_data got %h/%0d/%0d need 0/0/0",
               o_spk_data, o_spk_word_idx, o_spk_step);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_image();
    int bad;
    for (int p = 0; p < NP; p++) img[p] = 8'd0;
    load_image();
    do_start();
    collect(0, 0, 0);
    tot_cnt++;
    if (got_d.size() != NW*TS)
      $display("FAIL zero_count got %0d need %0d",
               got_d.size(), NW*TS);
    else pass_cnt++;
    bad = 0;
    foreach (got_d[k])
      if (got_d[k] !== '0 || got_w[k] != k % NW
          || got_s[k] != k / NW || got_l[k] != (k == NW*TS-1))
        bad++;
    tot_cnt++;
    if (bad != 0) $display("FAIL zero_beats got %0d bad need 0", bad);
    else pass_cnt++;
    tot_cnt++;
    if (n_done != 1 || o_busy !== 1'b0)
      $display("FAIL zero_done got done=%0d busy=%b need 1/0",
               n_done, o_busy);
    else pass_cnt++;
    @(negedge clk);
    tot_cnt++;
    if (o_done !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL zero_idle got done=%b busy=%b need 0/0",
               o_done, o_busy);
    else pass_cnt++;
  endtask

  task automatic test_single_pixel();
    int stray;
    int got_n;
    int exp_n;
    for (int p = 0; p < NP; p++) img[p] = 8'd0;
    img[37] = 8'd255;
    load_image();
    build_model();
    do_start();
    collect(0, 0, 0);
    stray = 0; got_n = 0; exp_n = 0;
    foreach (got_d[k]) begin
      if ((got_d[k] & ~(SW'(1) << 5)) != 0 || (got_w[k] != 1
          && got_d[k] != 0)) stray++;
      got_n += $countones(got_d[k]);
    end
    foreach (exp_q[k]) exp_n += $countones(exp_q[k]);
    tot_cnt++;
    if (stray != 0)
      $display("FAIL single_stray got %0d words need 0", stray);
    else pass_cnt++;
    tot_cnt++;
    if (got_n != exp_n)
      $display("FAIL single_count got %0d need %0d", got_n, exp_n);
    else pass_cnt++;
  endtask

  task automatic test_half();
    int ge;
    int gg;
    int tot;
    for (int p = 0; p < NP; p++) img[p] = 8'd128;
    load_image();
    build_model();
    do_start();
    collect(0, 0, 0);
    tot = 0;
    for (int s = 0; s < TS; s++) begin
      ge = 0; gg = 0;
      for (int k = 0; k < NW; k++) begin
        ge += $countones(exp_q[s*NW+k]);
        if (s*NW+k < got_d.size())
          gg += $countones(got_d[s*NW+k]);
      end
      tot += gg;
      tot_cnt++;
      if (gg != ge)
        $display("FAIL half_pop step %0d got %0d need %0d",
                 s, gg, ge);
      else pass_cnt++;
    end
    tot_cnt++;
    if (tot < NP*TS*3/8 || tot > NP*TS*5/8)
      $display("FAIL half_total got %0d need about %0d",
               tot, NP*TS/2);
    else pass_cnt++;
  endtask

  task automatic test_random_stream();
    for (int p = 0; p < NP; p++) img[p] = 8'($urandom);
    load_image();
    build_model();
    stab_err = 0;
    do_start();
    collect(1, 0, 0);
    tot_cnt++;
    if (got_d.size() != exp_q.size())
      $display("FAIL rand_count got %0d need %0d",
               got_d.size(), exp_q.size());
    else pass_cnt++;
    for (int k = 0; k < got_d.size() && k < exp_q.size(); k++) begin
      tot_cnt++;
      if (got_d[k] !== exp_q[k] || got_w[k] != k % NW
          || got_s[k] != k / NW || got_l[k] != (k == NW*TS-1))
        $display("FAIL rand_beat %0d got %h/%0d/%0d need %h/%0d/%0d",
                 k, got_d[k], got_w[k], got_s[k],
                 exp_q[k], k % NW, k / NW);
      else pass_cnt++;
    end
    tot_cnt++;
    if (stab_err != 0)
      $display("FAIL rand_hold got %0d changes need 0", stab_err);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int bad;
    stab_err = 0;
    do_start();
    collect(2, 10, 0);
    bad = 0;
    foreach (exp_q[k])
      if (k >= got_d.size() || got_d[k] !== exp_q[k]) bad++;
    tot_cnt++;
    if (bad != 0 || got_d.size() != exp_q.size())
      $display("FAIL stall_stream got %0d bad need 0", bad);
    else pass_cnt++;
    tot_cnt++;
    if (stab_err != 0)
      $display("FAIL stall_hold got %0d changes need 0", stab_err);
    else pass_cnt++;
  endtask

  task automatic test_busy_ignore();
    int bad;
    int a;
    i_spk_ready = 1'b0;
    do_start();
    for (int c = 0; c < 5; c++) begin
      a = $urandom_range(0, NP-1);
      i_pix_wr_en = 1'b1;
      i_pix_wr_addr = AW'(a);
      i_pix_wr_data = ~img[a];
      i_start = 1'b1;
      @(negedge clk);
    end
    i_pix_wr_en = 1'b0;
    i_start = 1'b0;
    collect(0, 0, 0);
    for (int r = 0; r < 2; r++) begin
      bad = 0;
      foreach (exp_q[k])
        if (k >= got_d.size() || got_d[k] !== exp_q[k]) bad++;
      tot_cnt++;
      if (bad != 0 || got_d.size() != exp_q.size())
        $display("FAIL busy_ignore run %0d got %0d bad need 0",
                 r, bad);
      else pass_cnt++;
      if (r == 0) begin
        @(negedge clk);
        do_start();
        collect(0, 0, 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    tot_cnt++;
    if (o_busy !== 1'b1 || o_done !== 1'b0)
      $display("FAIL b2b_start got busy=%b done=%b need 1/0",
               o_busy, o_done);
    else pass_cnt++;
    collect(0, 0, 0);
    bad = 0;
    foreach (exp_q[k])
      if (k >= got_d.size() || got_d[k] !== exp_q[k]) bad++;
    tot_cnt++;
    if (bad != 0 || got_d.size() != exp_q.size())
      $display("FAIL b2b_stream got %0d bad need 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_latency();
    int z;
    @(negedge clk);
    i_spk_ready = 1'b0;
    do_start();
    tot_cnt++;
    if (o_busy !== 1'b1)
      $display("FAIL lat_busy got %b need 1", o_busy);
    else pass_cnt++;
    z = 0;
    while (!o_spk_valid && z < 100) begin
      z++;
      @(negedge clk);
    end
    tot_cnt++;
    if (z != SW + 1)
      $display("FAIL lat_valid got %0d cycles need %0d", z, SW+1);
    else pass_cnt++;
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    tot_cnt++;
    if (o_spk_valid !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL lat_abort got v=%b busy=%b need 0/0",
               o_spk_valid, o_busy);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int dn;
    int bad;
    do_start();
    collect(0, 0, 3*NW+1);
    tot_cnt++;
    if (got_s.size() != 3*NW+1 || got_s[got_s.size()-1] != 3)
      $display("FAIL abort_reach got %0d beats need %0d",
               got_s.size(), 3*NW+1);
    else pass_cnt++;
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    tot_cnt++;
    if (o_busy !== 1'b0 || o_spk_valid !== 1'b0 || o_done !== 1'b0)
      $display("FAIL abort_idle got b=%b v=%b d=%b need 0/0/0",
               o_busy, o_spk_valid, o_done);
    else pass_cnt++;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (o_done) dn++;
    end
    tot_cnt++;
    if (dn != 0) $display("FAIL abort_done got %0d need 0", dn);
    else pass_cnt++;
    do_start();
    collect(0, 0, 0);
    bad = 0;
    foreach (exp_q[k])
      if (k >= got_d.size() || got_d[k] !== exp_q[k]) bad++;
    tot_cnt++;
    if (bad != 0 || got_d.size() != exp_q.size())
      $display("FAIL abort_restart got %0d bad need 0", bad);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    do_start();
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tot_cnt++;
    if ({o_busy, o_done, o_spk_valid, o_spk_last} !== 4'b0000
        || o_spk_data !== '0 || o_spk_word_idx !== '0
        || o_spk_step !== '0)
      $display("FAIL midreset got b=%b v=%b data=%h need 0",
               o_busy, o_spk_valid, o_spk_data);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tot_cnt++;
    if (o_busy !== 1'b0 || o_spk_valid !== 1'b0)
      $display("FAIL midreset_idle got b=%b v=%b need 0/0",
               o_busy, o_spk_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_zero_image();
    test_single_pixel();
    test_half();
    test_random_stream();
    test_stall();
    test_busy_ignore();
    test_back_to_back();
    test_latency();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
